// File: rtl/shift_deser_pkg.sv
// Shared definitions for the serial deserializer and its serializer peer.
package shift_deser_pkg;

  // Receiver FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  // Bit-order encoding shared with the serializer side.
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/deser_outbuf.sv
// One-word output holding register with a valid/ready handshake.
// A new word may be loaded while the held word is drained on the same edge.
module deser_outbuf
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_load_ok,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Buffer can take a word when empty or when it is being drained this edge.
  always_comb begin
    o_load_ok = !r_valid || i_ready;
  end

  // Load accepted words; otherwise clear valid on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load && o_load_ok) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: collects sof-framed bits into WIDTH-bit words
// and hands them to a one-word output buffer.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_sreg, w_sreg_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic             r_overrun, w_overrun_d;
  logic             r_frame_err, w_frame_err_d;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_first;
  logic             w_load;
  logic             w_load_ok;

  // Shifted value and the value for a fresh first bit (partial word dropped).
  always_comb begin
    if (MSB_FIRST) begin
      w_shift = {r_sreg[WIDTH-2:0], sin};
      w_first = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      w_shift = {sin, r_sreg[WIDTH-1:1]};
      w_first = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  // Next-state logic for FSM, counter, shift register and error flags.
  always_comb begin
    w_state_d     = r_state;
    w_sreg_d      = r_sreg;
    w_cnt_d       = r_cnt;
    w_frame_err_d = 1'b0;
    w_load        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bit_valid && sof) begin
          w_sreg_d  = w_first;
          w_cnt_d   = CW'(1);
          w_state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (bit_valid && sof) begin
          w_frame_err_d = 1'b1;
          w_sreg_d      = w_first;
          w_cnt_d       = CW'(1);
        end else if (bit_valid) begin
          w_sreg_d = w_shift;
          if (r_cnt == LAST_CNT) begin
            w_load    = 1'b1;
            w_cnt_d   = '0;
            w_state_d = ST_IDLE;
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    // Set wins over clear.
    w_overrun_d = clr_err ? 1'b0 : r_overrun;
    if (w_load && !w_load_ok) begin
      w_overrun_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_sreg      <= w_sreg_d;
      r_cnt       <= w_cnt_d;
      r_overrun   <= w_overrun_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  deser_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_data    (w_shift),
    .i_ready   (out_ready),
    .o_load_ok (w_load_ok),
    .o_data    (out_data),
    .o_valid   (out_valid)
  );

  assign busy      = (r_state == ST_RECV);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser: one MSB-first and one LSB-first instance
// share the same stimulus.
module tb_shift_deser;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin, bit_valid, sof, out_ready, clr_err;
  logic [3:0] m_data, l_data;
  logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr, m_ferr, l_ferr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .bit_valid (bit_valid),
    .sof       (sof),
    .out_data  (m_data),
    .out_valid (m_valid),
    .out_ready (out_ready),
    .busy      (m_busy),
    .overrun   (m_ovr),
    .frame_err (m_ferr),
    .clr_err   (clr_err)
  );

  shift_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .bit_valid (bit_valid),
    .sof       (sof),
    .out_data  (l_data),
    .out_valid (l_valid),
    .out_ready (out_ready),
    .busy      (l_busy),
    .overrun   (l_ovr),
    .frame_err (l_ferr),
    .clr_err   (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one valid bit for one edge; returns at the following negedge.
  task automatic send_bit(input logic s, input logic f);
    sin = s; sof = f; bit_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b0; sof = 1'b0; sin = 1'b0;
  endtask

  task automatic idle_cycle();
    bit_valid = 1'b0; sof = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    // Random inputs while held in reset.
    for (int i = 0; i < 2; i++) begin
      sin = 1'($urandom); bit_valid = 1'($urandom); sof = 1'($urandom);
      out_ready = 1'($urandom); clr_err = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst_data",  {28'd0, m_data}, 32'h0);
    chk("rst_valid", {31'd0, m_valid}, 32'h0);
    chk("rst_busy",  {31'd0, m_busy}, 32'h0);
    chk("rst_ovr",   {31'd0, m_ovr}, 32'h0);
    chk("rst_ferr",  {31'd0, m_ferr}, 32'h0);
    sin = 1'b0; bit_valid = 1'b0; sof = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    reset = 1'b1;
    idle_cycle();

    // Bit without sof in IDLE is ignored.
    send_bit(1'b1, 1'b0);
    chk("idle_nosof_busy", {31'd0, m_busy}, 32'h0);
    chk("idle_nosof_ferr", {31'd0, m_ferr}, 32'h0);

    // Basic word 1,1,0,1.
    send_bit(1'b1, 1'b1);
    chk("w1_busy", {31'd0, m_busy}, 32'h1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("w1_not_yet_valid", {31'd0, m_valid}, 32'h0);
    send_bit(1'b1, 1'b0);
    chk("w1_msb_data",  {28'd0, m_data}, 32'hD);
    chk("w1_msb_valid", {31'd0, m_valid}, 32'h1);
    chk("w1_lsb_data",  {28'd0, l_data}, 32'hB);
    chk("w1_busy_done", {31'd0, m_busy}, 32'h0);
    idle_cycle();
    chk("w1_valid_1cyc", {31'd0, m_valid}, 32'h0);

    // Backpressure: A=1101 held, B=0110 dropped.
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("bp_a_data", {28'd0, m_data}, 32'hD);
    chk("bp_a_ovr",  {31'd0, m_ovr}, 32'h0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    chk("bp_b_data",  {28'd0, m_data}, 32'hD);
    chk("bp_b_valid", {31'd0, m_valid}, 32'h1);
    chk("bp_b_ovr",   {31'd0, m_ovr}, 32'h1);
    out_ready = 1'b1;
    idle_cycle();
    chk("bp_drain_valid", {31'd0, m_valid}, 32'h0);
    chk("bp_ovr_sticky",  {31'd0, m_ovr}, 32'h1);
    clr_err = 1'b1;
    idle_cycle();
    clr_err = 1'b0;
    chk("bp_ovr_clr", {31'd0, m_ovr}, 32'h0);

    // Simultaneous drain and fill.
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("df_data",  {28'd0, m_data}, 32'h6);
    chk("df_valid", {31'd0, m_valid}, 32'h1);
    chk("df_ovr",   {31'd0, m_ovr}, 32'h0);
    idle_cycle();
    chk("df_drain", {31'd0, m_valid}, 32'h0);

    // Resync: sof,1,0 then sof,0,1,1,1.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("rs_no_ferr", {31'd0, m_ferr}, 32'h0);
    send_bit(1'b0, 1'b1);
    chk("rs_ferr_pulse", {31'd0, m_ferr}, 32'h1);
    chk("rs_busy", {31'd0, m_busy}, 32'h1);
    send_bit(1'b1, 1'b0);
    chk("rs_ferr_low", {31'd0, m_ferr}, 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("rs_data",  {28'd0, m_data}, 32'h7);
    chk("rs_valid", {31'd0, m_valid}, 32'h1);
    idle_cycle();

    // Mid-word asynchronous reset.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("mr_busy_before", {31'd0, m_busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mr_busy_async", {31'd0, m_busy}, 32'h0);
    chk("mr_data_async", {28'd0, m_data}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();

    // Gapped word 1,0,1,1 with bit_valid every other cycle.
    send_bit(1'b1, 1'b1); idle_cycle();
    send_bit(1'b0, 1'b0); idle_cycle();
    send_bit(1'b1, 1'b0); idle_cycle();
    chk("gap_busy_hold", {31'd0, m_busy}, 32'h1);
    chk("gap_no_valid",  {31'd0, m_valid}, 32'h0);
    send_bit(1'b1, 1'b0);
    chk("gap_msb_data", {28'd0, m_data}, 32'hB);
    chk("gap_lsb_data", {28'd0, l_data}, 32'hD);
    chk("gap_valid",    {31'd0, m_valid}, 32'h1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
